// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by the instruction fetch queue.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_REQ  = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Ring-buffer storage for fetched {pc, instr} entries with flush; head reads as zero when empty.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Pointer and occupancy state; flush empties the ring without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
      else                             r_count <= r_count;
    end
  end

  // Entry storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  assign valid = (r_count != '0);
  assign head  = valid ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one-outstanding-request fetcher feeding an ifq_fifo toward decode.
// Optional IFETCH_QUEUE_BYPASS_EN forwards an ack straight to the output when the queue is empty.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  ifq_state_t                r_state;
  ifq_state_t                w_state_nxt;
  logic [XLEN-1:0]           r_fetch_pc;
  logic [XLEN-1:0]           r_req_addr;
  logic                      w_ack_req;
  logic                      w_bypass;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_fifo_valid;
  logic [XLEN+INSTR_W-1:0]   w_head;
  logic [CW-1:0]             w_count;

  assign w_ack_req = (r_state == IFQ_REQ) && imem_ack && !redirect_valid;

`ifdef IFETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_ack_req && !w_fifo_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_ack_req && !(w_bypass && out_ready);
  assign w_pop  = w_fifo_valid && out_ready && !redirect_valid;

  // Fetch state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IFQ_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; an ack always retires the single outstanding request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IFQ_IDLE: begin
        if (!redirect_valid && (w_count < CW'(DEPTH))) w_state_nxt = IFQ_REQ;
        else                                           w_state_nxt = IFQ_IDLE;
      end
      IFQ_REQ: begin
        if (imem_ack)            w_state_nxt = IFQ_IDLE;
        else if (redirect_valid) w_state_nxt = IFQ_DROP;
        else                     w_state_nxt = IFQ_REQ;
      end
      IFQ_DROP: begin
        if (imem_ack) w_state_nxt = IFQ_IDLE;
        else          w_state_nxt = IFQ_DROP;
      end
      default: w_state_nxt = IFQ_IDLE;
    endcase
  end

  // Fetch PC and the latched request address that stays put while a dropped request drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (redirect_valid) r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_ack_req) r_fetch_pc <= r_fetch_pc + 32'd4;
      else                r_fetch_pc <= r_fetch_pc;
      if ((r_state == IFQ_IDLE) && (w_state_nxt == IFQ_REQ)) r_req_addr <= r_fetch_pc;
      else                                                   r_req_addr <= r_req_addr;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (XLEN + INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data ({r_fetch_pc, imem_rdata}),
    .pop       (w_pop),
    .valid     (w_fifo_valid),
    .head      (w_head),
    .count     (w_count)
  );

  assign imem_req  = (r_state != IFQ_IDLE);
  assign imem_addr = r_req_addr;
  assign count     = w_count;
  assign out_valid = w_fifo_valid || w_bypass;
  assign out_pc    = w_bypass ? r_fetch_pc : w_head[XLEN+INSTR_W-1:INSTR_W];
  assign out_instr = w_bypass ? imem_rdata : w_head[INSTR_W-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  logic [63:0] q[$];
  logic [31:0] exp_pc;
  bit          poisoned;
  bit          prev_req;
  bit          last_ack;
  logic [31:0] prev_addr;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_pc   = 32'h0;
    poisoned = 1'b0;
    prev_req = 1'b0;
    last_ack = 1'b0;
  endtask

  // Compare DUT outputs (sampled at negedge) against the queue model.
  task automatic check_state();
    checks++;
    if (count !== q.size()) begin failures++; $display("FAIL count: got %0d expected %0d", count, q.size()); end
    checks++;
    if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL out_valid: got %0b expected %0b", out_valid, q.size() != 0); end
    checks++;
    if (q.size() != 0) begin
      if ({out_pc, out_instr} !== q[0]) begin failures++; $display("FAIL head: got %h_%h expected %h", out_pc, out_instr, q[0]); end
    end else begin
      if ({out_pc, out_instr} !== 64'h0) begin failures++; $display("FAIL idle_out: got %h_%h expected 0", out_pc, out_instr); end
    end
    if (last_ack) begin
      checks++;
      if (imem_req !== 1'b0) begin failures++; $display("FAIL req_after_ack: got %b expected 0", imem_req); end
    end else if (imem_req === 1'b1 && prev_req) begin
      checks++;
      if (imem_addr !== prev_addr) begin failures++; $display("FAIL addr_stable: got %h expected %h", imem_addr, prev_addr); end
    end else if (imem_req === 1'b1) begin
      checks++;
      if (imem_addr !== exp_pc) begin failures++; $display("FAIL new_req_addr: got %h expected %h", imem_addr, exp_pc); end
      checks++;
      if (q.size() >= DEPTH) begin failures++; $display("FAIL req_when_full: got count %0d expected < %0d", q.size(), DEPTH); end
    end
  endtask

  // One clock cycle: drive inputs at negedge, advance the model over the edge, then check.
  task automatic tick(input bit rdy, input bit rd, input logic [31:0] rpc, input bit ack);
    bit ack_eff;
    bit accepted;
    bit empty_pre;
    out_ready      = rdy;
    redirect_valid = rd;
    redirect_pc    = rpc;
    ack_eff        = ack && (imem_req === 1'b1);
    imem_ack       = ack_eff;
    imem_rdata     = ack_eff ? instr_of(imem_addr) : $urandom;
    #1;
    accepted  = ack_eff && !poisoned && !rd;
    if (ack_eff)                     poisoned = 1'b0;
    else if (rd && imem_req === 1'b1) poisoned = 1'b1;
    empty_pre = (q.size() == 0);
    if (rd) begin
      q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (accepted) begin
        if (!(BYP && empty_pre && rdy)) q.push_back({exp_pc, instr_of(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
    end
    prev_addr = imem_addr;
    prev_req  = (imem_req === 1'b1) && !ack_eff;
    last_ack  = ack_eff;
    @(negedge clk);
    check_state();
  endtask

  task automatic wait_req(input bit rdy);
    for (int i = 0; i < 12 && imem_req !== 1'b1; i++) tick(rdy, 1'b0, 32'h0, 1'b0);
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL wait_req: got imem_req %b expected 1", imem_req); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({imem_req, out_valid, count, out_pc, out_instr} !== '0) begin
      failures++; $display("FAIL reset_outputs: got req=%b v=%b cnt=%0d pc=%h ins=%h expected all 0", imem_req, out_valid, count, out_pc, out_instr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_state();
  endtask

  task automatic test_fill_backpressure();
    for (int i = 0; i < 30 && int'(count) != DEPTH; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (int'(count) != DEPTH) begin failures++; $display("FAIL fill: got count %0d expected %0d", count, DEPTH); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL full_no_req: got %b expected 0", imem_req); end
    checks++;
    if (out_pc !== 32'h0) begin failures++; $display("FAIL first_pc: got %h expected 0", out_pc); end
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (count !== CW'(3) || out_pc !== 32'h4) begin failures++; $display("FAIL pop_one: got cnt=%0d pc=%h expected 3/4", count, out_pc); end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL refill_req: got %b/%h expected 1/10", imem_req, imem_addr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h4 + 32'(4 * k)) begin
        failures++; $display("FAIL stream_%0d: got v=%b pc=%h expected 1/%h", k, out_valid, out_pc, 32'h4 + 32'(4 * k));
      end
      tick(1'b1, 1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_redirect_drop();
    wait_req(1'b1);
    tick(1'b1, 1'b1, 32'h0000_0102, 1'b0);
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL redirect_drop: got cnt=%0d v=%b req=%b expected 0/0/1", count, out_valid, imem_req);
    end
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (count !== '0) begin failures++; $display("FAIL drop_ack: got cnt=%0d expected 0", count); end
    wait_req(1'b1);
    checks++;
    if (imem_addr !== 32'h0000_0100) begin failures++; $display("FAIL redirect_addr: got %h expected 100", imem_addr); end
    tick(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    checks++;
    if (count !== '0 || imem_req !== 1'b0) begin failures++; $display("FAIL redirect_with_ack: got cnt=%0d req=%b expected 0/0", count, imem_req); end
    wait_req(1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (out_pc !== 32'h0000_0200 || count !== CW'(1)) begin failures++; $display("FAIL after_redirect: got pc=%h cnt=%0d expected 200/1", out_pc, count); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 12 && !(imem_req === 1'b1 && !poisoned); i++) tick(1'b0, 1'b0, 32'h0, poisoned);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (out_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_entry: got %h expected fffffffc", out_pc); end
    wait_req(1'b0);
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next: got %h expected 0", imem_addr); end
  endtask

  task automatic test_async_reset();
    checks++;
    if (imem_req !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset: got req=%b v=%b expected 1/1", imem_req, out_valid); end
    #2 rst = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || count !== '0 || out_pc !== 32'h0) begin
      failures++; $display("FAIL async_reset: got req=%b v=%b cnt=%0d pc=%h expected 0", imem_req, out_valid, count, out_pc);
    end
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    check_state();
    wait_req(1'b0);
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL restart_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom,
           (imem_req === 1'b1) && ($urandom_range(0, 2) == 0));
    end
  endtask

`ifdef IFETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    tick(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    for (int i = 0; i < 12 && !(imem_req === 1'b1 && !poisoned); i++) tick(1'b1, 1'b0, 32'h0, poisoned);
    out_ready  = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = instr_of(imem_addr);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== instr_of(32'h40)) begin
      failures++; $display("FAIL bypass: got v=%b pc=%h ins=%h expected 1/40/%h", out_valid, out_pc, out_instr, instr_of(32'h40));
    end
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (count !== '0) begin failures++; $display("FAIL bypass_count: got %0d expected 0", count); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_backpressure();
    test_redirect_drop();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef IFETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
